// File: rtl/seq_gen_lfsr.sv
// ============================================================================
// seq_gen_lfsr : fills a table with LFSR-derived colour indices, reads one-hot
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module seq_gen_lfsr #(
   parameter int N_CORES = 4,
   parameter int ADDR_W  = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                inicio,
   input  logic [15:0]         semente,
   input  logic                fixo,
   input  logic                ler,
   input  logic [ADDR_W-1:0]   endereco,
   output logic [N_CORES-1:0]  saida,
   output logic                valido,
   output logic                ocupado,
   output logic                pronto
);

   localparam int CW    = $clog2(N_CORES);
   localparam int DEPTH = 1 << ADDR_W;

   localparam logic [15:0] c_seed_dflt = 16'hACE1;
   localparam logic [15:0] c_taps      = 16'hB400;

   localparam logic [1:0] c_idle  = 2'd0;
   localparam logic [1:0] c_fill  = 2'd1;
   localparam logic [1:0] c_ready = 2'd2;

   logic [1:0]          r_state;
   logic [15:0]         r_lfsr;
   logic [ADDR_W-1:0]   r_idx;
   logic [CW-1:0]       r_mem [DEPTH];
   logic [N_CORES-1:0]  r_saida;
   logic                r_valido;

   logic [15:0]         w_seed_load;
   logic [15:0]         w_lfsr_next;
   logic                w_fill_last;
   logic                w_wr_en;
   logic                w_rd_ok;
   logic [N_CORES-1:0]  w_onehot;

   // A zero seed would lock the LFSR, so it falls back to the default seed.
   assign w_seed_load = (fixo || (semente == 16'h0000)) ? c_seed_dflt : semente;
   assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_taps : 16'h0000);
   assign w_fill_last = (r_idx == ADDR_W'(DEPTH - 1));
   assign w_wr_en     = !reset && !inicio && (r_state == c_fill);
   assign w_rd_ok     = ler && !inicio && (r_state == c_ready);
   assign w_onehot    = {{(N_CORES-1){1'b0}}, 1'b1} << r_mem[endereco];

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= c_idle;
         r_lfsr  <= c_seed_dflt;
         r_idx   <= '0;
      end else if (inicio) begin
         r_state <= c_fill;
         r_lfsr  <= w_seed_load;
         r_idx   <= '0;
      end else begin
         case (r_state)
            c_fill: begin
               r_lfsr <= w_lfsr_next;
               r_idx  <= r_idx + 1'b1;
               if (w_fill_last) begin
                  r_state <= c_ready;
               end
            end
            c_idle, c_ready: begin
               r_state <= r_state;
            end
            default: begin
               r_state <= c_idle;
            end
         endcase
      end
   end

   // Table keeps only the colour index; contents are deliberately not reset.
   always_ff @(posedge clock) begin
      if (w_wr_en) begin
         r_mem[r_idx] <= r_lfsr[CW-1:0];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_saida  <= '0;
         r_valido <= 1'b0;
      end else begin
         r_valido <= w_rd_ok;
         if (w_rd_ok) begin
            r_saida <= w_onehot;
         end
      end
   end

   assign saida   = r_saida;
   assign valido  = r_valido;
   assign ocupado = (r_state == c_fill);
   assign pronto  = (r_state == c_ready);

endmodule

`default_nettype wire

// File: tb/tb_seq_gen_lfsr.sv
// ============================================================================
// tb_seq_gen_lfsr : directed + randomized checks of seq_gen_lfsr vs a model
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_seq_gen_lfsr;

   localparam int N_CORES = 4;
   localparam int ADDR_W  = 4;
   localparam int DEPTH   = 16;

   logic                clock = 1'b0;
   logic                reset = 1'b1;
   logic                inicio = 1'b0;
   logic [15:0]         semente = 16'h0000;
   logic                fixo = 1'b0;
   logic                ler = 1'b0;
   logic [ADDR_W-1:0]   endereco = '0;
   logic [N_CORES-1:0]  saida;
   logic                valido;
   logic                ocupado;
   logic                pronto;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_idx [DEPTH];
   logic [N_CORES-1:0] got [DEPTH];
   logic [N_CORES-1:0] ref_fixed [DEPTH];

   seq_gen_lfsr #(.N_CORES(N_CORES), .ADDR_W(ADDR_W)) dut (
      .clock(clock), .reset(reset), .inicio(inicio), .semente(semente),
      .fixo(fixo), .ler(ler), .endereco(endereco), .saida(saida),
      .valido(valido), .ocupado(ocupado), .pronto(pronto)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Inputs change and outputs are observed at the falling edge.
   task automatic tick();
      @(negedge clock);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference sequence straight from the arithmetic definition of the LFSR.
   task automatic build_model(input logic [15:0] seed, input bit fx);
      int v;
      v = (fx || seed == 16'h0000) ? 'hACE1 : int'(seed);
      for (int i = 0; i < DEPTH; i++) begin
         exp_idx[i] = v % N_CORES;
         v = (v / 2) ^ ((v % 2 == 1) ? 'hB400 : 0);
      end
   endtask

   task automatic start(input logic [15:0] seed, input bit fx);
      semente = seed;
      fixo    = fx;
      inicio  = 1'b1;
      tick();
      inicio  = 1'b0;
      semente = 16'($urandom);
      fixo    = 1'($urandom);
   endtask

   task automatic wait_fill(input string tag, input int expected);
      int cnt;
      cnt = 0;
      while (ocupado === 1'b1 && cnt < 40) begin
         check({tag, "_pronto_low"}, 32'(pronto), 32'd0);
         cnt++;
         tick();
      end
      check({tag, "_fill_len"}, cnt, expected);
      check({tag, "_pronto"}, 32'(pronto), 32'd1);
   endtask

   task automatic read_all(input string tag);
      for (int i = 0; i < DEPTH; i++) begin
         endereco = ADDR_W'(i);
         ler = 1'b1;
         tick();
         check({tag, "_valido"}, 32'(valido), 32'd1);
         check({tag, "_saida"}, 32'(saida), 32'd1 << exp_idx[i]);
         got[i] = saida;
      end
      ler = 1'b0;
      tick();
      check({tag, "_valido_end"}, 32'(valido), 32'd0);
   endtask

   initial begin
      logic [3:0] c_first [4];
      logic [3:0] held;
      int a0, a1, a2;
      c_first[0] = 4'b0010; c_first[1] = 4'b0001;
      c_first[2] = 4'b0001; c_first[3] = 4'b0001;

      // Reset state
      tick(); tick();
      reset = 1'b0;
      check("rst_saida", 32'(saida), 32'd0);
      check("rst_valido", 32'(valido), 32'd0);
      check("rst_ocupado", 32'(ocupado), 32'd0);
      check("rst_pronto", 32'(pronto), 32'd0);

      // Read in IDLE is ignored
      ler = 1'b1; endereco = 4'd3;
      tick();
      ler = 1'b0;
      check("idle_read_valido", 32'(valido), 32'd0);

      // Seed 1, with a read issued during FILL
      build_model(16'h0001, 1'b0);
      start(16'h0001, 1'b0);
      tick(); tick();
      ler = 1'b1; endereco = 4'($urandom);
      tick();
      ler = 1'b0;
      check("fill_read_valido", 32'(valido), 32'd0);
      check("fill_read_saida", 32'(saida), 32'd0);
      wait_fill("seed1", 13);
      read_all("seed1");
      for (int i = 0; i < 4; i++) check("seed1_const", 32'(got[i]), 32'(c_first[i]));

      // Fixed mode twice with different seeds
      build_model(16'hACE1, 1'b1);
      start(16'($urandom_range(1, 16'h7FFF)), 1'b1);
      wait_fill("fix_a", 16);
      read_all("fix_a");
      for (int i = 0; i < DEPTH; i++) ref_fixed[i] = got[i];
      check("fix_step0", 32'(ref_fixed[0]), 32'h2);
      start(16'($urandom_range(16'h8000, 16'hFFFF)), 1'b1);
      wait_fill("fix_b", 16);
      read_all("fix_b");
      for (int i = 0; i < DEPTH; i++) check("fix_repeat", 32'(got[i]), 32'(ref_fixed[i]));

      // Zero seed falls back to the fixed sequence
      start(16'h0000, 1'b0);
      wait_fill("zero", 16);
      read_all("zero");
      for (int i = 0; i < DEPTH; i++) check("zero_eq_fix", 32'(got[i]), 32'(ref_fixed[i]));

      // Back-to-back reads, then idle cycle; saida must hold afterwards
      a0 = int'($urandom_range(0, 15)); a1 = int'($urandom_range(0, 15)); a2 = int'($urandom_range(0, 15));
      ler = 1'b1; endereco = 4'(a0);
      tick(); check("b2b_v1", 32'(valido), 32'd1); check("b2b_s1", 32'(saida), 32'd1 << exp_idx[a0]);
      endereco = 4'(a1);
      tick(); check("b2b_v2", 32'(valido), 32'd1); check("b2b_s2", 32'(saida), 32'd1 << exp_idx[a1]);
      endereco = 4'(a2);
      tick(); check("b2b_v3", 32'(valido), 32'd1); check("b2b_s3", 32'(saida), 32'd1 << exp_idx[a2]);
      ler = 1'b0; held = saida;
      tick(); check("b2b_v4", 32'(valido), 32'd0); check("b2b_hold", 32'(saida), 32'(held));

      // Aborted fill: second seed must fully replace the first
      build_model(16'h1234, 1'b0);
      start(16'hBEEF, 1'b0);
      tick(); tick(); tick(); tick();
      start(16'h1234, 1'b0);
      wait_fill("abort", 16);
      read_all("abort");

      // ler together with inicio in READY: inicio wins
      endereco = 4'd0; ler = 1'b1; semente = 16'h5555; fixo = 1'b0; inicio = 1'b1;
      tick();
      inicio = 1'b0; ler = 1'b0;
      check("ler_inicio_valido", 32'(valido), 32'd0);
      check("ler_inicio_ocupado", 32'(ocupado), 32'd1);

      // Reset at FILL cycle 8
      for (int i = 0; i < 7; i++) tick();
      check("pre_rst_ocupado", 32'(ocupado), 32'd1);
      reset = 1'b1; inicio = 1'b1; ler = 1'b1;
      tick();
      reset = 1'b0; inicio = 1'b0; ler = 1'b0;
      check("midrst_saida", 32'(saida), 32'd0);
      check("midrst_valido", 32'(valido), 32'd0);
      check("midrst_ocupado", 32'(ocupado), 32'd0);
      check("midrst_pronto", 32'(pronto), 32'd0);
      for (int i = 0; i < 20; i++) tick();
      check("midrst_pronto_stays", 32'(pronto), 32'd0);

      // Randomized full runs after the reset
      for (int r = 0; r < 3; r++) begin
         logic [15:0] s;
         bit f;
         s = 16'($urandom);
         f = 1'($urandom);
         build_model(s, f);
         start(s, f);
         wait_fill("rand", 16);
         read_all("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
